// File: rtl/ps2_command_decoder_if.sv
// Scan-code / game-command bundle between the PS/2 front end, the decoder
// and the game state machine. The master side feeds bytes and game timing;
// the slave side (the decoder) returns committed directions and key events.
interface ps2_command_decoder_if;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       move_tick;
    logic       round_init;
    logic [1:0] p1_dir;
    logic [1:0] p2_dir;
    logic       start_pulse;
    logic       abort_pulse;
    logic [7:0] last_code;

    modport master (
        output scan_valid, scan_code, move_tick, round_init,
        input  p1_dir, p2_dir, start_pulse, abort_pulse, last_code
    );

    modport slave (
        input  scan_valid, scan_code, move_tick, round_init,
        output p1_dir, p2_dir, start_pulse, abort_pulse, last_code
    );
endinterface

// File: rtl/ps2_command_decoder.sv
// PS/2 set-2 scan-code to lightbike command decoder.
// Tracks E0/F0 prefixes, turns WASD / arrow makes into per-player turn
// requests held as pending until the move tick, blocks 180-degree reversals
// and emits one start/abort pulse per fresh Space/Esc press.
module ps2_command_decoder (
    input  logic                        board_clk,
    input  logic                        reset,
    ps2_command_decoder_if.slave        bus
);
    localparam logic [7:0] K_E0    = 8'hE0;
    localparam logic [7:0] K_F0    = 8'hF0;
    localparam logic [7:0] K_W     = 8'h1D;
    localparam logic [7:0] K_S     = 8'h1B;
    localparam logic [7:0] K_A     = 8'h1C;
    localparam logic [7:0] K_D     = 8'h23;
    localparam logic [7:0] K_UP    = 8'h75;
    localparam logic [7:0] K_DOWN  = 8'h72;
    localparam logic [7:0] K_LEFT  = 8'h6B;
    localparam logic [7:0] K_RIGHT = 8'h74;
    localparam logic [7:0] K_SPACE = 8'h29;
    localparam logic [7:0] K_ESC   = 8'h76;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t     r_state;
    logic       r_space_held;
    logic       r_esc_held;
    logic [1:0] r_p1_dir;
    logic [1:0] r_p1_pending;
    logic [1:0] r_p2_dir;
    logic [1:0] r_p2_pending;
    logic       r_start_pulse;
    logic       r_abort_pulse;
    logic [7:0] r_last_code;

    logic       w_is_e0;
    logic       w_is_f0;
    logic       w_prefix;
    logic       w_make;
    logic       w_make_ext;
    logic       w_release;
    logic       w_release_ext;
    logic       w_p1_req_valid;
    logic [1:0] w_p1_req_dir;
    logic       w_p2_req_valid;
    logic [1:0] w_p2_req_dir;
    logic [1:0] w_p1_ref;
    logic [1:0] w_p2_ref;
    logic       w_p1_accept;
    logic       w_p2_accept;
    logic       w_space_make;
    logic       w_space_release;
    logic       w_esc_make;
    logic       w_esc_release;

    assign bus.p1_dir      = r_p1_dir;
    assign bus.p2_dir      = r_p2_dir;
    assign bus.start_pulse = r_start_pulse;
    assign bus.abort_pulse = r_abort_pulse;
    assign bus.last_code   = r_last_code;

    // Classify the incoming byte against the prefix state and form turn requests.
    always_comb begin
        w_is_e0       = (bus.scan_code == K_E0);
        w_is_f0       = (bus.scan_code == K_F0);
        w_prefix      = w_is_e0 || w_is_f0;
        // A make completes from IDLE or EXT on any non-prefix byte.
        w_make        = bus.scan_valid && !w_prefix &&
                        ((r_state == ST_IDLE) || (r_state == ST_EXT));
        w_make_ext    = (r_state == ST_EXT);
        // After a break prefix, every byte (prefix values included) is the released key.
        w_release     = bus.scan_valid &&
                        ((r_state == ST_BRK) || (r_state == ST_EXT_BRK));
        w_release_ext = (r_state == ST_EXT_BRK);

        w_p1_req_valid = 1'b0;
        w_p1_req_dir   = DIR_UP;
        if (w_make) begin
            case (bus.scan_code)
                K_W:     begin w_p1_req_valid = 1'b1; w_p1_req_dir = DIR_UP;    end
                K_D:     begin w_p1_req_valid = 1'b1; w_p1_req_dir = DIR_RIGHT; end
                K_S:     begin w_p1_req_valid = 1'b1; w_p1_req_dir = DIR_DOWN;  end
                K_A:     begin w_p1_req_valid = 1'b1; w_p1_req_dir = DIR_LEFT;  end
                default: begin w_p1_req_valid = 1'b0; w_p1_req_dir = DIR_UP;    end
            endcase
        end

        // Arrows only count with E0; the same bytes bare are keypad keys.
        w_p2_req_valid = 1'b0;
        w_p2_req_dir   = DIR_UP;
        if (w_make && w_make_ext) begin
            case (bus.scan_code)
                K_UP:    begin w_p2_req_valid = 1'b1; w_p2_req_dir = DIR_UP;    end
                K_RIGHT: begin w_p2_req_valid = 1'b1; w_p2_req_dir = DIR_RIGHT; end
                K_DOWN:  begin w_p2_req_valid = 1'b1; w_p2_req_dir = DIR_DOWN;  end
                K_LEFT:  begin w_p2_req_valid = 1'b1; w_p2_req_dir = DIR_LEFT;  end
                default: begin w_p2_req_valid = 1'b0; w_p2_req_dir = DIR_UP;    end
            endcase
        end

        // On a tick the pending value is being committed, so filter against it.
        w_p1_ref    = bus.move_tick ? r_p1_pending : r_p1_dir;
        w_p2_ref    = bus.move_tick ? r_p2_pending : r_p2_dir;
        w_p1_accept = w_p1_req_valid && ((w_p1_req_dir ^ w_p1_ref) != 2'b10);
        w_p2_accept = w_p2_req_valid && ((w_p2_req_dir ^ w_p2_ref) != 2'b10);

        w_space_make    = w_make && !w_make_ext && (bus.scan_code == K_SPACE);
        w_esc_make      = w_make && !w_make_ext && (bus.scan_code == K_ESC);
        w_space_release = w_release && !w_release_ext && (bus.scan_code == K_SPACE);
        w_esc_release   = w_release && !w_release_ext && (bus.scan_code == K_ESC);
    end

    // Prefix FSM, held-key tracking, turn commit and all registered outputs.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_space_held  <= 1'b0;
            r_esc_held    <= 1'b0;
            r_p1_dir      <= DIR_RIGHT;
            r_p1_pending  <= DIR_RIGHT;
            r_p2_dir      <= DIR_LEFT;
            r_p2_pending  <= DIR_LEFT;
            r_start_pulse <= 1'b0;
            r_abort_pulse <= 1'b0;
            r_last_code   <= 8'h00;
        end else begin
            if (bus.scan_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_is_e0)      r_state <= ST_EXT;
                        else if (w_is_f0) r_state <= ST_BRK;
                        else              r_state <= ST_IDLE;
                    end
                    ST_EXT: begin
                        if (w_is_e0)      r_state <= ST_EXT;
                        else if (w_is_f0) r_state <= ST_EXT_BRK;
                        else              r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
                if (!w_prefix) r_last_code <= bus.scan_code;
            end

            r_start_pulse <= w_space_make && !r_space_held;
            r_abort_pulse <= w_esc_make && !r_esc_held;
            if (w_space_make)         r_space_held <= 1'b1;
            else if (w_space_release) r_space_held <= 1'b0;
            if (w_esc_make)           r_esc_held <= 1'b1;
            else if (w_esc_release)   r_esc_held <= 1'b0;

            if (bus.round_init) begin
                r_p1_dir     <= DIR_RIGHT;
                r_p1_pending <= DIR_RIGHT;
                r_p2_dir     <= DIR_LEFT;
                r_p2_pending <= DIR_LEFT;
            end else begin
                if (bus.move_tick) begin
                    r_p1_dir <= r_p1_pending;
                    r_p2_dir <= r_p2_pending;
                end
                if (w_p1_accept) r_p1_pending <= w_p1_req_dir;
                if (w_p2_accept) r_p2_pending <= w_p2_req_dir;
            end
        end
    end
endmodule

// File: tb/tb_ps2_command_decoder.sv
// Randomised and directed bench for ps2_command_decoder against a
// flag-based behavioural model of the key protocol and turn rules.
module tb_ps2_command_decoder;
    logic board_clk = 1'b0;
    logic reset     = 1'b1;

    ps2_command_decoder_if bus ();

    ps2_command_decoder dut (
        .board_clk (board_clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 board_clk = ~board_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit       m_ext, m_brk, m_sp_held, m_esc_held;
    bit [1:0] m_dir  [2];
    bit [1:0] m_pend [2];
    bit       m_start, m_abort;
    bit [7:0] m_last;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model one clock edge using the key-protocol rules directly.
    task automatic model_step(input bit rst, input bit valid, input bit [7:0] code,
                              input bit tick, input bit init);
        bit       rv [2];
        bit [1:0] rd [2];
        bit [1:0] ref_d;
        rv[0] = 0; rv[1] = 0; rd[0] = 0; rd[1] = 0;
        if (rst) begin
            m_ext = 0; m_brk = 0; m_sp_held = 0; m_esc_held = 0;
            m_dir[0] = 2'd1; m_pend[0] = 2'd1; m_dir[1] = 2'd3; m_pend[1] = 2'd3;
            m_start = 0; m_abort = 0; m_last = 8'h00;
            return;
        end
        m_start = 0; m_abort = 0;
        if (valid) begin
            if (m_brk) begin
                if (!m_ext && code == 8'h29) m_sp_held = 0;
                if (!m_ext && code == 8'h76) m_esc_held = 0;
                m_ext = 0; m_brk = 0;
            end else if (code == 8'hF0) begin
                m_brk = 1;
            end else if (code == 8'hE0) begin
                m_ext = 1;
            end else begin
                case (code)
                    8'h1D: begin rv[0] = 1; rd[0] = 0; end
                    8'h23: begin rv[0] = 1; rd[0] = 1; end
                    8'h1B: begin rv[0] = 1; rd[0] = 2; end
                    8'h1C: begin rv[0] = 1; rd[0] = 3; end
                    default: ;
                endcase
                if (m_ext) begin
                    case (code)
                        8'h75: begin rv[1] = 1; rd[1] = 0; end
                        8'h74: begin rv[1] = 1; rd[1] = 1; end
                        8'h72: begin rv[1] = 1; rd[1] = 2; end
                        8'h6B: begin rv[1] = 1; rd[1] = 3; end
                        default: ;
                    endcase
                end else begin
                    if (code == 8'h29) begin m_start = !m_sp_held;  m_sp_held = 1;  end
                    if (code == 8'h76) begin m_abort = !m_esc_held; m_esc_held = 1; end
                end
                m_ext = 0;
            end
            if (code != 8'hE0 && code != 8'hF0) m_last = code;
        end
        for (int p = 0; p < 2; p++) begin
            if (init) begin
                m_dir[p]  = (p == 0) ? 2'd1 : 2'd3;
                m_pend[p] = m_dir[p];
            end else begin
                ref_d = tick ? m_pend[p] : m_dir[p];
                if (tick) m_dir[p] = m_pend[p];
                // Reverse means opposite sides of the compass: differ by two quarter turns.
                if (rv[p] && ((rd[p] + 2'd2) != ref_d)) m_pend[p] = rd[p];
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit valid, input bit [7:0] code,
                         input bit tick, input bit init);
        reset          = rst;
        bus.scan_valid = valid;
        bus.scan_code  = code;
        bus.move_tick  = tick;
        bus.round_init = init;
        @(posedge board_clk);
        model_step(rst, valid, code, tick, init);
        #1;
        $display("txn rst=%0d v=%0d code=%02h tick=%0d init=%0d -> p1=%0d p2=%0d st=%0d ab=%0d last=%02h",
                 rst, valid, code, tick, init, bus.p1_dir, bus.p2_dir,
                 bus.start_pulse, bus.abort_pulse, bus.last_code);
        check_val("p1_dir",      {6'd0, bus.p1_dir},      {6'd0, m_dir[0]});
        check_val("p2_dir",      {6'd0, bus.p2_dir},      {6'd0, m_dir[1]});
        check_val("start_pulse", {7'd0, bus.start_pulse}, {7'd0, m_start});
        check_val("abort_pulse", {7'd0, bus.abort_pulse}, {7'd0, m_abort});
        check_val("last_code",   bus.last_code,           m_last);
    endtask

    task automatic send(input bit [7:0] code);
        cycle(0, 1, code, 0, 0);
    endtask

    task automatic tick();
        cycle(0, 0, 8'h00, 1, 0);
    endtask

    bit [7:0] pool [13] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B,
                            8'h74, 8'h29, 8'h76, 8'hE0, 8'hF0, 8'h12};

    initial begin
        bus.scan_valid = 0; bus.scan_code = 0; bus.move_tick = 0; bus.round_init = 0;
        cycle(1, 0, 8'h00, 0, 0);
        cycle(1, 1, 8'h29, 1, 0);
        // Reset values, fixed constants
        check_val("rst_p1", {6'd0, bus.p1_dir}, 8'h01);
        check_val("rst_p2", {6'd0, bus.p2_dir}, 8'h03);
        check_val("rst_last", bus.last_code, 8'h00);

        // Space press, typematic repeats, release, fresh press
        send(8'h29);
        check_val("space_first", {7'd0, bus.start_pulse}, 8'h01);
        check_val("space_last",  bus.last_code, 8'h29);
        send(8'h29); send(8'h29);
        send(8'hF0); send(8'h29); send(8'h29);
        cycle(0, 0, 8'h00, 0, 0);

        // Arrows: extended counts, keypad ignored, break does nothing
        send(8'hE0); send(8'h75); tick();
        check_val("arrow_up", {6'd0, bus.p2_dir}, 8'h00);
        send(8'h72); tick();
        send(8'hE0); send(8'hF0); send(8'h6B); tick();
        check_val("arrow_brk", {6'd0, bus.p2_dir}, 8'h00);

        // Reversal filter against committed direction
        send(8'h1C); tick();
        check_val("p1_rev", {6'd0, bus.p1_dir}, 8'h01);
        send(8'h1D); send(8'h1C); tick();
        check_val("p1_up", {6'd0, bus.p1_dir}, 8'h00);

        // Request in tick cycle filtered against pending being committed
        send(8'h23); tick();
        send(8'h1D);
        cycle(0, 1, 8'h1C, 1, 0);
        check_val("same_cycle", {6'd0, bus.p1_dir}, 8'h00);
        tick();
        check_val("same_next", {6'd0, bus.p1_dir}, 8'h03);

        // round_init overrides requests and ticks; Esc still fires
        cycle(0, 1, 8'h1D, 1, 1);
        cycle(0, 0, 8'h00, 1, 1);
        cycle(0, 1, 8'h76, 0, 1);
        check_val("init_abort", {7'd0, bus.abort_pulse}, 8'h01);
        check_val("init_p1", {6'd0, bus.p1_dir}, 8'h01);
        check_val("init_p2", {6'd0, bus.p2_dir}, 8'h03);

        // Reset mid-prefix drops the E0
        send(8'hE0);
        cycle(1, 0, 8'h00, 0, 0);
        send(8'h75); tick();
        check_val("rst_prefix_p2", {6'd0, bus.p2_dir}, 8'h03);
        check_val("rst_prefix_last", bus.last_code, 8'h75);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 2) != 0),
                  pool[$urandom_range(0, 12)],
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 49) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ps2_command_decoder.md
# ps2_command_decoder

Converts the one-cycle-validated PS/2 scan-code byte stream into game commands for the lightbike state machine. It tracks the E0 (extended) and F0 (break) prefixes, so arrow keys and key releases decode correctly. It suppresses typematic repeats of Space and Esc, and rejects 180° reversals. Requested turns are held as pending and committed only on the game's move tick. It sits between the PS/2 receiver and pulse generator upstream and the game state machine and seven-segment display downstream.

## Interface
- Parameters:
  - None. Key codes are fixed localparams: W 1D, S 1B, A 1C, D 23, arrows E0-75/72/6B/74, Space 29, Esc 76.
- Ports:
  - board_clk  in  1  system clock; all state updates on the rising edge.
  - reset  in  1  Reset is synchronous and active-high; the block is clocked by board_clk.
  - scan_valid  in  1  one-cycle pulse; scan_code is valid in that cycle.
  - scan_code  in  8  raw PS/2 set-2 byte.
  - move_tick  in  1  one-cycle pulse; pending directions become committed.
  - round_init  in  1  level; forces both players' initial directions.
  - p1_dir  out  2  committed player-1 direction.
  - p2_dir  out  2  committed player-2 direction.
  - start_pulse  out  1  one-cycle pulse on a fresh Space press.
  - abort_pulse  out  1  one-cycle pulse on a fresh Esc press.
  - last_code  out  8  last non-prefix byte received, for the SSD.

## Operation
- Direction encoding: UP=00, RIGHT=01, DOWN=10, LEFT=11. Two directions are reverses when they XOR to 2'b10.
- Prefix FSM has four states: IDLE, EXT, BRK, EXT_BRK. It advances only on scan_valid.
  - From IDLE: E0 goes to EXT; F0 goes to BRK; any other byte is decoded as a non-extended make code and the FSM stays in IDLE.
  - From EXT: F0 goes to EXT_BRK; E0 stays in EXT; any other byte is decoded as an extended make code and the FSM returns to IDLE.
  - From BRK or EXT_BRK: any byte is treated as a release of that key (E0 or F0 bytes included) and the FSM returns to IDLE.
- Make decode:
  - WASD sets p1_req.
  - Arrows set p2_req, but only when E0-prefixed. Non-extended 75/72/6B/74 (keypad) are ignored.
  - Space and Esc count only when non-extended.
- Space handling:
  - A Space make with space_held=0 asserts start_pulse and sets space_held.
  - Further Space makes while space_held=1 (typematic repeats) produce no pulse.
  - A Space release clears space_held.
- Esc handling uses esc_held in the same way and drives abort_pulse.
- Turn filter, per player:
  - A requested direction is written to pending only if it is not the reverse of the reference direction.
  - The reference direction is the committed direction, except in a move_tick cycle, where it is the old pending value (the value being committed).
  - The last accepted request before a tick wins.
- move_tick copies p1_pending to p1_dir and p2_pending to p2_dir.
- round_init has the highest priority:
  - p1_dir and p1_pending load RIGHT; p2_dir and p2_pending load LEFT.
  - Direction requests and ticks are ignored while round_init is high.
  - Prefix and held tracking continue normally, and start_pulse/abort_pulse still fire.
- last_code is updated with every byte except E0 and F0.

## Timing
- Reset values:
  - FSM is IDLE; space_held and esc_held are 0.
  - p1_dir and p1_pending are RIGHT (01); p2_dir and p2_pending are LEFT (11).
  - start_pulse and abort_pulse are 0; last_code is 00.
- All outputs are registered:
  - start_pulse and abort_pulse are high for exactly the cycle after the scan_valid that completes the make code.
  - last_code updates in the cycle after scan_valid.
  - pending updates in the cycle after scan_valid; p*_dir changes in the cycle after move_tick.
- scan_valid may arrive on back-to-back cycles and each byte is consumed. There is no back-pressure.
- Reset asserted mid-sequence (e.g. after E0) discards the prefix. The next byte is decoded from IDLE.
- scan_valid and move_tick in the same cycle: the commit uses the old pending, and the new request is filtered against that value.
- scan_valid with reset high: the byte is ignored.

## Test plan
- Reset, then byte 29 -> start_pulse high for 1 cycle; last_code=29. Then 29, 29 (repeats) -> no pulse. Then F0, 29, 29 -> one pulse.
- E0, 75, then move_tick -> p2_dir=00. Non-extended 75 then tick -> p2_dir unchanged. E0, F0, 75 -> no direction change, FSM back in IDLE.
- p1_dir=RIGHT, byte 1C (LEFT) then tick -> p1_dir stays 01. Then 1D (UP), 1C (LEFT), tick -> p1_dir=00, because LEFT is filtered against committed RIGHT.
- p1_dir=RIGHT, pending=UP; 1C arrives in the same cycle as move_tick -> p1_dir=00 and pending=11. Next tick -> p1_dir=11.
- round_init high with 1D and ticks applied -> p1_dir=01 and p2_dir=11 held. Byte 76 during round_init -> abort_pulse still fires.
- Send E0, assert reset for 1 cycle, then send 75 -> treated as non-extended and ignored; last_code=75.
